st_bus_ctrl: RTL and testbench

//  Slave-side bus cycle controller behind the 68000-compatible CPU bus wrapper.

---
 rtl/st_bus_pkg.sv | 20 ++
 rtl/st_bus_ctrl_decode.sv | 27 ++
 rtl/st_bus_ctrl.sv | 127 ++++++++++++
 tb/tb_st_bus_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/st_bus_pkg.sv
// Shared types and address map for the ST bus cycle controller.
package st_bus_pkg;

  typedef enum logic [2:0] {R_NONE, R_RAM, R_ROM, R_IO, R_IACK, R_TRAP} region_t;
  typedef enum logic [1:0] {IDLE, DECODE, WAIT, ACK} state_t;

  localparam logic [23:0] ROM_BASE = 24'hFC0000;
  localparam logic [23:0] ROM_TOP  = 24'hFEFFFF;
  localparam logic [23:0] IO_BASE  = 24'hFF8000;
  localparam logic [23:0] SUPV_TOP = 24'h000800;
  localparam logic [23:0] VEC_TOP  = 24'h000007;

  // Level n maps to mask bit n-1; level 0 never autovectors.
  function automatic logic autovec_hit(input logic [6:0] mask, input logic [2:0] lvl);
    logic [7:0] m;
    m = {mask, 1'b0};
    return m[lvl];
  endfunction

endpackage

// File: rtl/st_bus_ctrl_decode.sv
// Combinational region decode of a CPU bus cycle.
module st_addr_decode
  import st_bus_pkg::*;
#(
  parameter logic [23:0] RAM_TOP = 24'h3FFFFF
) (
  input  logic [22:0] addr,
  input  logic [2:0]  fc,
  input  logic        rw_n,
  output region_t     region
);

  logic [23:0] baddr;
  assign baddr = {addr, 1'b0};

  // The reset-vector shadow must beat RAM, otherwise it could never be reached.
  always_comb begin
    region = R_NONE;
    if (fc == 3'b111)                                region = R_IACK;
    else if (!rw_n && !fc[2] && baddr < SUPV_TOP)    region = R_TRAP;
    else if (rw_n && baddr <= VEC_TOP)               region = R_ROM;
    else if (baddr <= RAM_TOP)                       region = R_RAM;
    else if (baddr >= ROM_BASE && baddr <= ROM_TOP)  region = R_ROM;
    else if (baddr >= IO_BASE)                       region = R_IO;
  end

endmodule

// File: rtl/st_bus_ctrl.sv
// Slave-side 68000 bus cycle controller: decode, wait states, timeout,
// supervisor write trap and autovector interrupt acknowledge.
module st_bus_ctrl
  import st_bus_pkg::*;
#(
  parameter int unsigned RAM_WAIT     = 2,
  parameter int unsigned ROM_WAIT     = 2,
  parameter int unsigned BERR_TIMEOUT = 64,
  parameter logic [23:0] RAM_TOP      = 24'h3FFFFF,
  parameter logic [6:0]  AUTOVEC_MASK = 7'b0010100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        phi1,
  input  logic        phi2,
  input  logic        as_n,
  input  logic        rw_n,
  input  logic        uds_n,
  input  logic        lds_n,
  input  logic [2:0]  fc,
  input  logic [22:0] addr,
  input  logic        io_dtack_n,
  input  logic        io_vpa,
  output logic        dtack_n,
  output logic        vpa_n,
  output logic        berr,
  output logic        ram_cs,
  output logic        rom_cs,
  output logic        io_cs,
  output logic        iack,
  output logic [2:0]  iack_lvl
);

  localparam logic [7:0] RAM_W = 8'(RAM_WAIT);
  localparam logic [7:0] ROM_W = 8'(ROM_WAIT);
  localparam logic [7:0] TMO   = 8'(BERR_TIMEOUT);

  state_t     state;
  region_t    region_d, region_q;
  logic [7:0] cnt, cnt_inc, wait_lim;
  logic       tick, mem_hit, io_hit, tmo_hit;

  // Byte strobes go straight to the slaves; this block never qualifies on them.
  logic strobes_unused;
  assign strobes_unused = uds_n & lds_n;

  st_addr_decode #(.RAM_TOP(RAM_TOP)) u_dec (
    .addr   (addr),
    .fc     (fc),
    .rw_n   (rw_n),
    .region (region_d)
  );

  assign tick     = phi1 | phi2;
  assign cnt_inc  = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  assign wait_lim = (region_q == R_ROM) ? ROM_W : RAM_W;
  assign mem_hit  = (region_q == R_RAM || region_q == R_ROM) && cnt_inc == wait_lim;
  assign io_hit   = (region_q == R_IO || region_q == R_IACK) && !io_dtack_n;
  assign tmo_hit  = cnt_inc == TMO;

  always_ff @(posedge clk) begin
    if (reset || as_n) begin
      state    <= IDLE;
      region_q <= R_NONE;
      cnt      <= 8'd0;
      dtack_n  <= 1'b1;
      vpa_n    <= 1'b1;
      berr     <= 1'b0;
      ram_cs   <= 1'b0;
      rom_cs   <= 1'b0;
      io_cs    <= 1'b0;
      iack     <= 1'b0;
      iack_lvl <= 3'd0;
    end else begin
      case (state)
        IDLE: if (tick) state <= DECODE;
        DECODE: if (tick) begin
          region_q <= region_d;
          cnt      <= 8'd0;
          ram_cs   <= (region_d == R_RAM);
          rom_cs   <= (region_d == R_ROM);
          io_cs    <= (region_d == R_IO);
          state    <= WAIT;
          case (region_d)
            R_TRAP: begin
              berr  <= 1'b1;
              state <= ACK;
            end
            R_IACK: begin
              // addr[2:0] carries A3..A1, the level being acknowledged
              if (autovec_hit(AUTOVEC_MASK, addr[2:0])) begin
                vpa_n <= 1'b0;
                state <= ACK;
              end else begin
                iack     <= 1'b1;
                iack_lvl <= addr[2:0];
              end
            end
            R_RAM: if (RAM_W == 8'd0) begin
              dtack_n <= 1'b0;
              state   <= ACK;
            end
            R_ROM: if (ROM_W == 8'd0) begin
              dtack_n <= 1'b0;
              state   <= ACK;
            end
            default: ;
          endcase
        end
        WAIT: if (phi2) begin
          cnt <= cnt_inc;
          if (mem_hit || io_hit) begin
            if (io_hit && io_vpa) vpa_n <= 1'b0;
            else                  dtack_n <= 1'b0;
            state <= ACK;
          end else if (tmo_hit) begin
            berr  <= 1'b1;
            state <= ACK;
          end
        end
        ACK: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_st_bus_ctrl.sv
// Bench for st_bus_ctrl: directed table, reset/abort sequences and random cycles.
module tb_st_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        phi1 = 1'b0, phi2 = 1'b0;
  logic        as_n = 1'b1, rw_n = 1'b1, uds_n = 1'b1, lds_n = 1'b1;
  logic [2:0]  fc = 3'b000;
  logic [22:0] addr = 23'd0;
  logic        io_dtack_n = 1'b1, io_vpa = 1'b0;
  logic        dtack_n, vpa_n, berr, ram_cs, rom_cs, io_cs, iack;
  logic [2:0]  iack_lvl;
  logic [1:0]  ph = 2'd0;

  int checks = 0;
  int errors = 0;

  localparam logic [9:0] IDLE_OUT = 10'b11_0000_0000;
  localparam logic [6:0] AVMASK   = 7'b0010100;

  // kind: 0 none, 1 dtack, 2 vpa, 3 berr; n = WAIT phi2 ticks until it shows (0 = right after decode)
  typedef struct {
    string       name;
    logic [23:0] baddr;
    logic [2:0]  fc;
    logic        rw;
    int          k;      // WAIT phi2 tick at which io_dtack_n is low (0 = never)
    logic        vpa_io;
    int          abort;  // drop as_n after this many WAIT phi2 ticks (0 = no abort)
    logic [2:0]  cs;     // {ram, rom, io}
    logic        iack;
    logic [2:0]  lvl;
    int          kind;
    int          n;
  } vec_t;

  vec_t tbl[20];

  st_bus_ctrl dut (
    .clk(clk), .reset(reset), .phi1(phi1), .phi2(phi2), .as_n(as_n), .rw_n(rw_n),
    .uds_n(uds_n), .lds_n(lds_n), .fc(fc), .addr(addr), .io_dtack_n(io_dtack_n),
    .io_vpa(io_vpa), .dtack_n(dtack_n), .vpa_n(vpa_n), .berr(berr), .ram_cs(ram_cs),
    .rom_cs(rom_cs), .io_cs(io_cs), .iack(iack), .iack_lvl(iack_lvl)
  );

  always #5 clk = ~clk;

  // phi1 and phi2 each fire once every four clocks, two clocks apart
  always @(negedge clk) begin
    ph   <= ph + 2'd1;
    phi1 <= (ph == 2'd3);
    phi2 <= (ph == 2'd1);
  end

  function automatic vec_t mk(string nm, logic [23:0] ba, logic [2:0] f, logic rw, int k,
                              logic vp, int ab, logic [2:0] cs, logic iq, logic [2:0] lv,
                              int kind, int n);
    vec_t v;
    v.name = nm; v.baddr = ba; v.fc = f; v.rw = rw; v.k = k; v.vpa_io = vp; v.abort = ab;
    v.cs = cs; v.iack = iq; v.lvl = lv; v.kind = kind; v.n = n;
    return v;
  endfunction

  // Reference model: address map and response rules, 2 wait states, 64-tick timeout.
  function automatic vec_t model(logic [23:0] ba, logic [2:0] f, logic rw, int k, logic vp);
    vec_t v;
    int   lvl;
    v = mk("rand", ba, f, rw, k, vp, 0, 3'b000, 1'b0, 3'd0, 3, 64);
    lvl = int'(ba[3:1]);
    if (f == 3'b111) begin
      if (lvl != 0 && AVMASK[lvl-1]) begin
        v.kind = 2; v.n = 0;
      end else begin
        v.iack = 1'b1; v.lvl = ba[3:1];
        if (k >= 1 && k <= 64) begin v.kind = vp ? 2 : 1; v.n = k; end
      end
    end else if (!rw && f < 3'd4 && ba < 24'h000800) begin
      v.kind = 3; v.n = 0;
    end else if (rw && ba < 24'h000008) begin
      v.cs = 3'b010; v.kind = 1; v.n = 2;
    end else if (ba <= 24'h3FFFFF) begin
      v.cs = 3'b100; v.kind = 1; v.n = 2;
    end else if (ba >= 24'hFC0000 && ba < 24'hFF0000) begin
      v.cs = 3'b010; v.kind = 1; v.n = 2;
    end else if (ba >= 24'hFF8000) begin
      v.cs = 3'b001;
      if (k >= 1 && k <= 64) begin v.kind = vp ? 2 : 1; v.n = k; end
    end
    return v;
  endfunction

  task automatic check_out(input string nm, input logic [9:0] exp);
    logic [9:0] act;
    act = {dtack_n, vpa_n, berr, ram_cs, rom_cs, io_cs, iack, iack_lvl};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b (dtack_n,vpa_n,berr,ram,rom,io,iack,lvl) at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Enters on a negedge; drives one bus cycle and checks outputs every clock.
  task automatic run_cycle(input vec_t v);
    int         ticks, wseen, held, clks;
    bit         dec, done, resp;
    logic [9:0] exp;
    ticks = 0; wseen = 0; held = 0; clks = 0; dec = 0; done = 0;
    addr = v.baddr[23:1]; fc = v.fc; rw_n = v.rw; io_vpa = v.vpa_io; io_dtack_n = 1'b1;
    as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0;
    while (!done) begin
      @(posedge clk);
      clks++;
      if (phi1 || phi2) begin
        if (dec && phi2) wseen++;
        ticks++;
        if (ticks == 2) dec = 1;
      end
      #1;
      resp = dec && (wseen >= v.n);
      exp = {!(resp && v.kind == 1), !(resp && v.kind == 2), resp && v.kind == 3,
             dec ? v.cs : 3'b000, dec && v.iack, (dec && v.iack) ? v.lvl : 3'd0};
      check_out(v.name, exp);
      if (resp) held++;
      if (held >= 2 || (v.abort > 0 && dec && wseen >= v.abort)) done = 1;
      if (clks > 400) begin
        checks++; errors++;
        $display("FAIL %s: cycle not finished within 400 clocks", v.name);
        done = 1;
      end
      @(negedge clk);
      io_dtack_n = !(v.k > 0 && dec && wseen >= v.k - 1);
    end
    as_n = 1'b1; io_dtack_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    @(posedge clk); #1;
    check_out({v.name, "_release"}, IDLE_OUT);
    @(negedge clk);
  endtask

  initial begin
    vec_t        v;
    int          cls;
    logic [23:0] ba;
    logic [2:0]  f;

    tbl[0]  = mk("ram_rd",      24'h001000, 3'b110, 1'b1, 0,  1'b0, 0,  3'b100, 1'b0, 3'd0, 1, 2);
    tbl[1]  = mk("rom_vec_rd",  24'h000004, 3'b110, 1'b1, 0,  1'b0, 0,  3'b010, 1'b0, 3'd0, 1, 2);
    tbl[2]  = mk("supv_wr_vec", 24'h000004, 3'b101, 1'b0, 0,  1'b0, 0,  3'b100, 1'b0, 3'd0, 1, 2);
    tbl[3]  = mk("user_trap",   24'h000400, 3'b001, 1'b0, 0,  1'b0, 0,  3'b000, 1'b0, 3'd0, 3, 0);
    tbl[4]  = mk("iack5_auto",  24'hFFFFFA, 3'b111, 1'b1, 0,  1'b0, 0,  3'b000, 1'b0, 3'd0, 2, 0);
    tbl[5]  = mk("iack6_vec",   24'hFFFFFC, 3'b111, 1'b1, 3,  1'b0, 0,  3'b000, 1'b1, 3'd6, 1, 3);
    tbl[6]  = mk("none_tmo",    24'hA00000, 3'b110, 1'b1, 0,  1'b0, 0,  3'b000, 1'b0, 3'd0, 3, 64);
    tbl[7]  = mk("io_ack64",    24'hFF8000, 3'b110, 1'b1, 64, 1'b0, 0,  3'b001, 1'b0, 3'd0, 1, 64);
    tbl[8]  = mk("io_vpa",      24'hFFFC00, 3'b110, 1'b1, 5,  1'b1, 0,  3'b001, 1'b0, 3'd0, 2, 5);
    tbl[9]  = mk("rom_hi",      24'hFC0100, 3'b110, 1'b1, 0,  1'b0, 0,  3'b010, 1'b0, 3'd0, 1, 2);
    tbl[10] = mk("user_wr_800", 24'h000800, 3'b001, 1'b0, 0,  1'b0, 0,  3'b100, 1'b0, 3'd0, 1, 2);
    tbl[11] = mk("ram_top",     24'h3FFFFE, 3'b110, 1'b1, 0,  1'b0, 0,  3'b100, 1'b0, 3'd0, 1, 2);
    tbl[12] = mk("past_ram",    24'h400000, 3'b101, 1'b0, 0,  1'b0, 0,  3'b000, 1'b0, 3'd0, 3, 64);
    tbl[13] = mk("rom_top",     24'hFEFFFE, 3'b110, 1'b1, 0,  1'b0, 0,  3'b010, 1'b0, 3'd0, 1, 2);
    tbl[14] = mk("io_late",     24'hFF8002, 3'b110, 1'b1, 65, 1'b0, 0,  3'b001, 1'b0, 3'd0, 3, 64);
    tbl[15] = mk("abort10",     24'hA00000, 3'b110, 1'b1, 0,  1'b0, 10, 3'b000, 1'b0, 3'd0, 3, 64);
    tbl[16] = mk("rd_0008",     24'h000008, 3'b110, 1'b1, 0,  1'b0, 0,  3'b100, 1'b0, 3'd0, 1, 2);
    tbl[17] = mk("user_wr_vec", 24'h000004, 3'b010, 1'b0, 0,  1'b0, 0,  3'b000, 1'b0, 3'd0, 3, 0);
    tbl[18] = mk("iack3_auto",  24'hFFFFF6, 3'b111, 1'b1, 0,  1'b0, 0,  3'b000, 1'b0, 3'd0, 2, 0);
    tbl[19] = mk("iack6_iovpa", 24'hFFFFFC, 3'b111, 1'b1, 1,  1'b1, 0,  3'b000, 1'b1, 3'd6, 2, 1);

    repeat (4) @(negedge clk);
    check_out("reset_state", IDLE_OUT);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 20; i++) run_cycle(tbl[i]);

    // reset in the middle of a WAIT, then a normal cycle
    addr = 23'h500000; fc = 3'b110; rw_n = 1'b1; as_n = 1'b0;
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_out("reset_mid_wait", IDLE_OUT);
    @(negedge clk);
    reset = 1'b0; as_n = 1'b1;
    @(posedge clk); #1;
    check_out("reset_release", IDLE_OUT);
    @(negedge clk);
    run_cycle(tbl[0]);

    for (int i = 0; i < 40; i++) begin
      cls = int'($urandom_range(0, 5));
      case (cls)
        0:       ba = 24'($urandom_range(0, 32'h3FFFFF));
        1:       ba = 24'($urandom_range(0, 32'hFFF));
        2:       ba = 24'($urandom_range(32'hFC0000, 32'hFEFFFF));
        3:       ba = 24'($urandom_range(32'hFF8000, 32'hFFFFFF));
        4:       ba = 24'($urandom_range(32'h400000, 32'hFBFFFF));
        default: ba = 24'hFFFFF0 | 24'($urandom_range(0, 7) << 1);
      endcase
      ba[0] = 1'b0;
      f = (cls == 5) ? 3'b111 : 3'($urandom_range(0, 6));
      v = model(ba, f, 1'($urandom_range(0, 1)), int'($urandom_range(0, 70)),
                1'($urandom_range(0, 1)));
      if ($urandom_range(0, 7) == 0 && v.n > 1) v.abort = int'($urandom_range(1, v.n - 1));
      run_cycle(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
